operand_mux_rr: RTL and testbench
=================================

Name: operand_mux_rr

Overview:
- Parametrised N:1 operand-select multiplexer with one registered output stage and valid/ready handshakes on every input and on the output.
- Generalises the single-bit 2:1 gate-level mux to NUM_IN channels of WIDTH bits each.
- Adds two selection modes: explicit select, and round-robin arbitration among valid channels.
- Sits in front of the ALU operand ports so that several producers (register file, immediate path, forwarding path) can share one ALU input.

Parameters:
- WIDTH, 8, data bits per channel (≥1).
- NUM_IN, 4, number of input channels (≥2; non-power-of-two supported).
- SEL_W, 2, select/index width; must equal clog2(NUM_IN).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset (sampled on clk; 0 = reset asserted).
- mode  input  1  0 = explicit select via sel; 1 = round-robin among valid inputs.
- sel  input  SEL_W  channel index used when mode=0.
- in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready; at most one bit high in any cycle.
- out_data  output  WIDTH  registered selected data.
- out_src  output  SEL_W  index of the channel that produced out_data.
- out_valid  output  1  out_data/out_src hold a pending item.
- out_ready  input  1  consumer accepts the pending item.

Behaviour:
- Reset (reset=0 at a clk edge):
  - Outputs: out_valid=0, out_data=0, out_src=0.
  - Internal round-robin pointer rr_ptr=0.
  - in_ready is forced to all-0 combinationally while reset=0.
  - Reset mid-transfer discards the pending item; no partial state survives.
- Load enable: load = !out_valid | out_ready. The output register accepts a new item only when load=1. This gives full throughput of one item per cycle.
- Grant, mode=0:
  - grant_valid = (sel < NUM_IN) & in_valid[sel]; g = sel.
  - sel ≥ NUM_IN means no grant, never an X.
- Grant, mode=1:
  - g = first index i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, … with wrap from NUM_IN-1 to 0.
  - grant_valid = |in_valid.
- in_ready[i] = reset & load & grant_valid & (i==g).
  - in_ready depends combinationally on in_valid, mode, sel and out_ready.
  - Producers must not make in_valid depend on in_ready.
- Transfer occurs on channel g when in_valid[g] & in_ready[g]. At that clk edge:
  - out_data <= channel g data; out_src <= g; out_valid <= 1.
  - If mode=1: rr_ptr <= (g==NUM_IN-1) ? 0 : g+1.
  - If mode=0: rr_ptr is unchanged.
- load=1 with no grant: out_valid <= 0. out_data and out_src keep their last values (don't-care when out_valid=0).
- Stall (out_valid=1 & out_ready=0): out_data, out_src and out_valid are held stable; all in_ready=0; rr_ptr is held.
- Simultaneous drain and fill (out_valid=1, out_ready=1, grant_valid=1): old item leaves and new item loads in the same edge; out_valid stays 1.
- Latency: a transfer at edge N makes the item visible on out_* immediately after edge N (1-cycle register latency).
- Mode or sel changes take effect for the grant decision in the same cycle. An already-registered item is unaffected.
- Fairness (mode=1): with all inputs continuously valid and out_ready=1, grant order is 0,1,…,NUM_IN-1,0,… with no channel starved more than NUM_IN-1 transfers.
- in_valid is don't-care during reset.
- No arithmetic beyond the index increment; the index wraps modulo NUM_IN, not modulo 2^SEL_W.

Test Plan:
- Reset: hold reset=0 for 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0, out_src=0. Release -> first grant is channel 0 (mode=1).
- Explicit select: mode=0, sel=2, in_data ch2=8'hA5, in_valid=0100, out_ready=1 -> in_ready=0100; next cycle out_data=A5, out_src=2, out_valid=1. Then sel=3 with in_valid[3]=0 -> no grant, out_valid drops to 0.
- Round-robin fairness: mode=1, in_valid=1111, data ch i = 8'h10+i, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3 with out_valid=1 every cycle after the first.
- Round-robin wrap/skip: mode=1, rr_ptr=3 (after a grant to ch2), in_valid=0011 -> grant ch0, then ch1, then ch0.
- Backpressure: out_valid=1 with out_src=1 and out_data=11, out_ready=0 for 3 cycles while in_valid=1111 -> in_ready=0000, outputs stable. Raise out_ready -> drain-and-fill in the same edge, next out_src=2.
- Mid-operation reset and out-of-range sel: NUM_IN=3, SEL_W=2, mode=0, sel=3 -> in_ready=000. Then assert reset while out_valid=1 -> out_valid=0 next edge; after release the first mode=1 grant is ch0.

Source files
------------

// File: rtl/operand_mux_rr_if.sv
// Handshake bundle between operand producers, the operand mux and the ALU input.
// The producer/consumer side uses the master modport; the mux uses the slave modport.
interface operand_mux_rr_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
);
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_src;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_src, out_valid
  );
endinterface

// File: rtl/operand_mux_rr.sv
// N:1 operand-select mux with explicit-select or round-robin arbitration and a
// single registered output stage; one item per cycle at full throughput.
module operand_mux_rr #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input logic              clk,
  input logic              reset,
  operand_mux_rr_if.slave  bus
);

  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_src_q,  out_src_d;
  logic              out_valid_q, out_valid_d;
  logic [SEL_W-1:0]  rr_ptr_q,   rr_ptr_d;

  logic              load;
  logic              grant_valid;
  logic [SEL_W-1:0]  grant_idx;
  logic [WIDTH-1:0]  grant_data;
  logic [NUM_IN-1:0] in_ready;

  assign load = !out_valid_q || bus.out_ready;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    logic [SEL_W-1:0] cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (!bus.mode) begin
      // sel values >= NUM_IN match no channel and therefore grant nothing.
      for (int i = 0; i < NUM_IN; i++) begin
        if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'(i);
        end
      end
    end else begin
      // Scan from farthest to nearest so the valid channel closest to rr_ptr wins.
      for (int k = NUM_IN - 1; k >= 0; k--) begin
        if (int'(rr_ptr_q) + k >= NUM_IN) cand = SEL_W'(int'(rr_ptr_q) + k - NUM_IN);
        else                              cand = SEL_W'(int'(rr_ptr_q) + k);
        if (bus.in_valid[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_idx == SEL_W'(i)) grant_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    in_ready = '0;
    if (reset && load && grant_valid) in_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      if (grant_valid) begin
        out_data_d  = grant_data;
        out_src_d   = grant_idx;
        out_valid_d = 1'b1;
        if (bus.mode) begin
          rr_ptr_d = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_operand_mux_rr.sv
// Self-checking bench: a 4-input and a 3-input operand_mux_rr driven with directed
// and random stimulus, compared every cycle against a behavioural arbitration model.
module tb_operand_mux_rr;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  operand_mux_rr_if #(.WIDTH(W), .NUM_IN(4), .SEL_W(2)) bus_a ();
  operand_mux_rr_if #(.WIDTH(W), .NUM_IN(3), .SEL_W(2)) bus_b ();

  operand_mux_rr #(.WIDTH(W), .NUM_IN(4), .SEL_W(2)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a.slave)
  );

  operand_mux_rr #(.WIDTH(W), .NUM_IN(3), .SEL_W(2)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state per instance: 0 = 4-input, 1 = 3-input.
  int nin[2] = '{4, 3};
  int m_valid[2];
  int m_data[2];
  int m_src[2];
  int m_ptr[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Which channel the spec's rules pick, computed with plain modular arithmetic.
  function automatic void ref_grant(input int n, input bit mode, input int sel, input int vmask,
                                    input int ptr, output bit gv, output int g);
    gv = 1'b0;
    g  = 0;
    if (!mode) begin
      if (sel < n && ((vmask >> sel) & 1) == 1) begin
        gv = 1'b1;
        g  = sel;
      end
    end else begin
      for (int k = 0; k < n; k++) begin
        int c;
        c = (ptr + k) % n;
        if (!gv && ((vmask >> c) & 1) == 1) begin
          gv = 1'b1;
          g  = c;
        end
      end
    end
  endfunction

  // Compare both DUTs against the model, clock once, advance the model.
  task automatic step();
    bit          md[2], ordy[2], rs[2], gv[2], ld[2];
    int          sl[2], vm[2], g[2];
    logic [31:0] din[2], o_rdy[2], o_val[2], o_dat[2], o_src[2];
    string       pfx[2] = '{"A", "B"};
    #1;
    md[0] = bus_a.mode;  sl[0] = int'(bus_a.sel);  vm[0] = int'(bus_a.in_valid);
    din[0] = 32'(bus_a.in_data);  ordy[0] = bus_a.out_ready;  rs[0] = rst_a;
    o_rdy[0] = 32'(bus_a.in_ready);  o_val[0] = 32'(bus_a.out_valid);
    o_dat[0] = 32'(bus_a.out_data);  o_src[0] = 32'(bus_a.out_src);
    md[1] = bus_b.mode;  sl[1] = int'(bus_b.sel);  vm[1] = int'(bus_b.in_valid);
    din[1] = 32'(bus_b.in_data);  ordy[1] = bus_b.out_ready;  rs[1] = rst_b;
    o_rdy[1] = 32'(bus_b.in_ready);  o_val[1] = 32'(bus_b.out_valid);
    o_dat[1] = 32'(bus_b.out_data);  o_src[1] = 32'(bus_b.out_src);
    for (int u = 0; u < 2; u++) begin
      ref_grant(nin[u], md[u], sl[u], vm[u], m_ptr[u], gv[u], g[u]);
      ld[u] = (m_valid[u] == 0) || ordy[u];
      check({pfx[u], ".in_ready"},  o_rdy[u], (rs[u] && ld[u] && gv[u]) ? (32'd1 << g[u]) : 32'd0);
      check({pfx[u], ".out_valid"}, o_val[u], 32'(m_valid[u]));
      check({pfx[u], ".out_data"},  o_dat[u], 32'(m_data[u]));
      check({pfx[u], ".out_src"},   o_src[u], 32'(m_src[u]));
    end
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      if (!rs[u]) begin
        m_valid[u] = 0; m_data[u] = 0; m_src[u] = 0; m_ptr[u] = 0;
      end else if (ld[u]) begin
        if (gv[u]) begin
          m_data[u]  = int'((din[u] >> (g[u] * W)) & 32'hFF);
          m_src[u]   = g[u];
          m_valid[u] = 1;
          if (md[u]) m_ptr[u] = (g[u] + 1) % nin[u];
        end else begin
          m_valid[u] = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      m_valid[u] = 0; m_data[u] = 0; m_src[u] = 0; m_ptr[u] = 0;
    end
    rst_a = 1'b0; rst_b = 1'b0;
    bus_a.mode = 1'b1; bus_a.sel = 2'd0; bus_a.in_data = 32'h0; bus_a.in_valid = 4'hF; bus_a.out_ready = 1'b1;
    bus_b.mode = 1'b0; bus_b.sel = 2'd0; bus_b.in_data = 24'h0; bus_b.in_valid = 3'b000; bus_b.out_ready = 1'b1;
    @(negedge clk);

    // Reset held two cycles with every channel valid.
    step();
    step();
    check("rst.in_ready",  32'(bus_a.in_ready), 32'h0);
    check("rst.out_valid", 32'(bus_a.out_valid), 32'h0);
    check("rst.out_data",  32'(bus_a.out_data), 32'h0);
    check("rst.out_src",   32'(bus_a.out_src), 32'h0);
    rst_a = 1'b1; rst_b = 1'b1;
    #1 check("rel.first_grant", 32'(bus_a.in_ready), 32'h1);
    step();

    // Explicit select of channel 2, then an invalid channel 3.
    bus_a.mode = 1'b0; bus_a.sel = 2'd2; bus_a.in_data = 32'h00A5_0000; bus_a.in_valid = 4'b0100;
    #1 check("sel2.in_ready", 32'(bus_a.in_ready), 32'h4);
    step();
    check("sel2.out_data",  32'(bus_a.out_data), 32'hA5);
    check("sel2.out_src",   32'(bus_a.out_src), 32'h2);
    check("sel2.out_valid", 32'(bus_a.out_valid), 32'h1);
    bus_a.sel = 2'd3;
    step();
    check("sel3.out_valid", 32'(bus_a.out_valid), 32'h0);

    // Round-robin fairness from a freshly reset pointer.
    rst_a = 1'b0;
    step();
    rst_a = 1'b1;
    bus_a.mode = 1'b1; bus_a.in_valid = 4'hF; bus_a.in_data = 32'h1312_1110;
    for (int i = 0; i < 8; i++) begin
      step();
      check("rr.out_src",   32'(bus_a.out_src), 32'(i % 4));
      check("rr.out_valid", 32'(bus_a.out_valid), 32'h1);
    end

    // Grant to channel 2 leaves the pointer at 3; then wrap and skip.
    bus_a.in_valid = 4'b0100;
    step();
    bus_a.in_valid = 4'b0011;
    step(); check("wrap.src0", 32'(bus_a.out_src), 32'h0);
    step(); check("wrap.src1", 32'(bus_a.out_src), 32'h1);
    step(); check("wrap.src2", 32'(bus_a.out_src), 32'h0);

    // Backpressure on channel 1's item, then drain-and-fill.
    bus_a.in_valid = 4'hF;
    step();
    check("bp.load_src",  32'(bus_a.out_src), 32'h1);
    check("bp.load_data", 32'(bus_a.out_data), 32'h11);
    bus_a.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp.hold_src",  32'(bus_a.out_src), 32'h1);
      check("bp.hold_data", 32'(bus_a.out_data), 32'h11);
    end
    bus_a.out_ready = 1'b1;
    #1 check("bp.ready_back", 32'(bus_a.in_ready), 32'h4);
    step();
    check("bp.fill_src",   32'(bus_a.out_src), 32'h2);
    check("bp.fill_valid", 32'(bus_a.out_valid), 32'h1);

    // Three-input instance: out-of-range select and mid-operation reset.
    bus_b.mode = 1'b0; bus_b.sel = 2'd1; bus_b.in_valid = 3'b111; bus_b.in_data = 24'h33_22_11;
    step();
    check("b.sel1_valid", 32'(bus_b.out_valid), 32'h1);
    bus_b.sel = 2'd3; bus_b.out_ready = 1'b0;
    #1 check("b.sel3_ready", 32'(bus_b.in_ready), 32'h0);
    rst_b = 1'b0;
    step();
    check("b.rst_valid", 32'(bus_b.out_valid), 32'h0);
    rst_b = 1'b1; bus_b.mode = 1'b1; bus_b.out_ready = 1'b1;
    step();
    check("b.first_rr", 32'(bus_b.out_src), 32'h0);

    // Random traffic on both instances, with occasional resets.
    for (int c = 0; c < 500; c++) begin
      rst_a = ($urandom_range(0, 39) != 0);
      rst_b = ($urandom_range(0, 39) != 0);
      bus_a.mode = 1'($urandom); bus_a.sel = 2'($urandom); bus_a.in_valid = 4'($urandom);
      bus_a.in_data = $urandom; bus_a.out_ready = ($urandom_range(0, 9) < 7);
      bus_b.mode = 1'($urandom); bus_b.sel = 2'($urandom); bus_b.in_valid = 3'($urandom);
      bus_b.in_data = 24'($urandom); bus_b.out_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
